// File: rtl/crate_bus_pkg.sv
// crate_bus_pkg: shared definitions for the crate bus capture path.
//   - decoded port codes (PORT_A/B/C, PORT_NONE marks the illegal code)
//   - bit positions of the module/port/qualifier fields inside crate_addr
//   - crate_rec_t record carried by the capture FIFO
//   - idle values loaded into the input synchronisers on reset
//   - capture FSM state encoding
package crate_bus_pkg;

  localparam logic [1:0] PORT_A    = 2'd0;
  localparam logic [1:0] PORT_B    = 2'd1;
  localparam logic [1:0] PORT_C    = 2'd2;
  localparam logic [1:0] PORT_NONE = 2'd3;

  localparam int MOD_LSB  = 0;
  localparam int MOD_MSB  = 4;
  localparam int PORT_LSB = 5;
  localparam int PORT_MSB = 6;
  localparam int QUAL_LSB = 7;
  localparam int QUAL_MSB = 9;

  typedef struct packed {
    logic [4:0] module_id;
    logic [1:0] port;
    logic [7:0] data;
  } crate_rec_t;

  localparam int REC_W = $bits(crate_rec_t);

  // The crate address lines are active-low, so an idle bus reads all ones.
  localparam logic [9:0] IDLE_ADDR     = 10'h3FF;
  localparam logic [7:0] IDLE_DATA     = 8'h00;
  localparam logic       IDLE_TRANSFER = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_SAMPLE   = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_t;

endpackage

// File: rtl/crate_rec_fifo.sv
// crate_rec_fifo: first-word fall-through FIFO of crate_rec_t records.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (empties the FIFO)
//   push         write push_rec; accepted when not full, or when full with
//                a same-cycle pop
//   push_rec     record to write
//   pop          remove the head record (ignored when empty)
//   head         head record, all zeros while empty
//   full, empty  occupancy flags
//   count        exact occupancy, 0..DEPTH
module crate_rec_fifo
  import crate_bus_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [REC_W-1:0]         push_rec,
  input  logic                     pop,
  output logic [REC_W-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  crate_rec_t        mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign do_pop  = pop && !empty;
  // When full, the slot under wr_ptr is the head being popped this cycle,
  // so the write can reuse it.
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= crate_rec_t'(push_rec);
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/crate_bus_capture.sv
// crate_bus_capture: synchronises the asynchronous crate bus, waits for it
// to settle after each transfer strobe, decodes and checks the cycle, and
// queues legal records for the downstream write logic.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   crate_addr[9:0]       raw active-low address: [4:0] module, [6:5] port,
//                         [9:7] qualifier
//   crate_data[7:0]       raw data, true polarity
//   transfer              asynchronous strobe, rising edge starts a cycle
//   rec_valid/rec_ready   record handshake (see below)
//   rec_module/port/data  head record fields, zero while empty
//   rec_count             FIFO occupancy
//   overflow              sticky: a legal record was dropped on a full FIFO
//   reject_count          saturating count of illegal and runt cycles
//   drop_count            saturating count of dropped records
//   clear_status          pulse clearing overflow and both counters; wins
//                         over any same-cycle update
//   debug_state           current capture FSM state
//
// Handshake: rec_valid is high whenever the FIFO holds a record and the
// rec_* fields show that head record; the head is consumed on every clock
// edge where rec_valid && rec_ready. rec_valid does not wait for rec_ready,
// and the fields stay stable until the record is consumed.
module crate_bus_capture
  import crate_bus_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [9:0]                    crate_addr,
  input  logic [7:0]                    crate_data,
  input  logic                          transfer,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [4:0]                    rec_module,
  output logic [1:0]                    rec_port,
  output logic [7:0]                    rec_data,
  output logic [$clog2(FIFO_DEPTH):0]   rec_count,
  output logic                          overflow,
  output logic [7:0]                    reject_count,
  output logic [7:0]                    drop_count,
  input  logic                          clear_status,
  output logic [1:0]                    debug_state
);

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);

  // Input synchronisers
  logic [9:0] addr_sync [SYNC_STAGES];
  logic [7:0] data_sync [SYNC_STAGES];
  logic       tr_sync   [SYNC_STAGES];
  logic       tr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_sync[i] <= IDLE_ADDR;
        data_sync[i] <= IDLE_DATA;
        tr_sync[i]   <= IDLE_TRANSFER;
      end
      tr_d <= IDLE_TRANSFER;
    end else begin
      addr_sync[0] <= crate_addr;
      data_sync[0] <= crate_data;
      tr_sync[0]   <= transfer;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        addr_sync[i] <= addr_sync[i-1];
        data_sync[i] <= data_sync[i-1];
        tr_sync[i]   <= tr_sync[i-1];
      end
      tr_d <= tr_sync[SYNC_STAGES-1];
    end
  end

  logic [9:0] addr_s;
  logic [7:0] data_s;
  logic       tr_s;
  logic       tr_rise;
  logic       tr_fall;

  assign addr_s  = addr_sync[SYNC_STAGES-1];
  assign data_s  = data_sync[SYNC_STAGES-1];
  assign tr_s    = tr_sync[SYNC_STAGES-1];
  assign tr_rise = tr_s && !tr_d;
  assign tr_fall = !tr_s && tr_d;

  // Decode of the synchronised sample (fields are active-low on the bus)
  logic [4:0] dec_module;
  logic [1:0] dec_port;
  logic [2:0] dec_qual;
  logic       dec_illegal;

  assign dec_module  = ~addr_s[MOD_MSB:MOD_LSB];
  assign dec_port    = ~addr_s[PORT_MSB:PORT_LSB];
  assign dec_qual    = ~addr_s[QUAL_MSB:QUAL_LSB];
  assign dec_illegal = (dec_module == 5'd0) || (dec_port == PORT_NONE) ||
                       (dec_qual == 3'd0);

  // Capture FSM
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       push;
  logic       reject_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    reject_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tr_rise) begin
          cnt_d   = SETTLE_INIT;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // A strobe that drops before the bus has settled is a runt; the
        // fall test comes first so a late fall still counts as a runt.
        if (tr_fall) begin
          reject_inc = 1'b1;
          state_d    = ST_IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SAMPLE: begin
        if (dec_illegal) begin
          reject_inc = 1'b1;
        end else begin
          push = 1'b1;
        end
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!tr_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign debug_state = state_q;

  // Record FIFO
  crate_rec_t push_rec;
  crate_rec_t head_rec;
  logic [REC_W-1:0] head_bits;
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic drop;

  assign push_rec.module_id = dec_module;
  assign push_rec.port      = dec_port;
  assign push_rec.data      = data_s;

  assign pop  = rec_valid && rec_ready;
  assign drop = push && fifo_full && !pop;

  crate_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_rec (push_rec),
    .pop      (pop),
    .head     (head_bits),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (rec_count)
  );

  assign head_rec   = crate_rec_t'(head_bits);
  assign rec_valid  = !fifo_empty;
  assign rec_module = head_rec.module_id;
  assign rec_port   = head_rec.port;
  assign rec_data   = head_rec.data;

  // Status: clear_status discards any same-cycle event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow     <= 1'b0;
      reject_count <= '0;
      drop_count   <= '0;
    end else if (clear_status) begin
      overflow     <= 1'b0;
      reject_count <= '0;
      drop_count   <= '0;
    end else begin
      if (reject_inc && reject_count != 8'hFF) begin
        reject_count <= reject_count + 8'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_crate_bus_capture.sv
// tb_crate_bus_capture: scenario-based bench for crate_bus_capture with a
// queue-based model of the records that should come out of the FIFO.
module tb_crate_bus_capture;

  logic       clk;
  logic       reset;
  logic [9:0] crate_addr;
  logic [7:0] crate_data;
  logic       transfer;
  logic       rec_valid;
  logic       rec_ready;
  logic [4:0] rec_module;
  logic [1:0] rec_port;
  logic [7:0] rec_data;
  logic [3:0] rec_count;
  logic       overflow;
  logic [7:0] reject_count;
  logic [7:0] drop_count;
  logic       clear_status;
  logic [1:0] debug_state;

  int checks = 0;
  int errors = 0;

  // Expected model state
  logic [14:0] exp_q[$];
  int          exp_reject;
  int          exp_drop;
  logic        exp_overflow;

  localparam logic [9:0] LEGAL_ADDR = 10'b0111111110;  // module 1, port A, qual 4
  localparam int         LATENCY    = 9;
  localparam int         DEPTH      = 8;

  crate_bus_capture dut (
    .clk          (clk),
    .reset        (reset),
    .crate_addr   (crate_addr),
    .crate_data   (crate_data),
    .transfer     (transfer),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_module   (rec_module),
    .rec_port     (rec_port),
    .rec_data     (rec_data),
    .rec_count    (rec_count),
    .overflow     (overflow),
    .reject_count (reject_count),
    .drop_count   (drop_count),
    .clear_status (clear_status),
    .debug_state  (debug_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Bench-side reading of the decode rules
  function automatic bit is_legal(input logic [9:0] a);
    logic [9:0] n;
    n = ~a;
    return (n[4:0] != 5'd0) && (n[6:5] != 2'd3) && (n[9:7] != 3'd0);
  endfunction

  function automatic logic [14:0] make_rec(input logic [9:0] a, input logic [7:0] d);
    logic [9:0] n;
    n = ~a;
    return {n[4:0], n[6:5], d};
  endfunction

  // Driver tasks
  task automatic drive_strobe(input logic [9:0] a, input logic [7:0] d,
                              input int high, input int gap);
    @(negedge clk);
    crate_addr = a;
    crate_data = d;
    transfer   = 1'b1;
    repeat (high) @(posedge clk);
    #1 transfer = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    exp_reject   = 0;
    exp_drop     = 0;
    exp_overflow = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    reset        = 1'b1;
    crate_addr   = 10'h3FF;
    crate_data   = 8'h00;
    transfer     = 1'b0;
    rec_ready    = 1'b1;
    clear_status = 1'b0;
    exp_reject   = 0;
    exp_drop     = 0;
    exp_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rec_valid); end
    checks++;
    if (rec_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", rec_count); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rec_module, rec_port, rec_data} !== 15'd0) begin
      errors++; $display("FAIL reset_fields got %h want 0", {rec_module, rec_port, rec_data});
    end
    checks++;
    if ({overflow, reject_count, drop_count} !== 17'd0) begin
      errors++; $display("FAIL reset_status got ovf=%b rej=%0d drop=%0d want 0/0/0",
                         overflow, reject_count, drop_count);
    end
    checks++;
    if (rec_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b want 0", rec_valid); end
  endtask

  // Watches rec_valid on each edge of a legal cycle; it must rise exactly at
  // the nominal latency and, with rec_ready high, last one cycle.
  task automatic test_legal(input string name, input logic [7:0] d);
    logic [14:0] exp_rec;
    exp_rec = make_rec(LEGAL_ADDR, d);
    rec_ready = 1'b1;
    @(negedge clk);
    crate_addr = LEGAL_ADDR;
    crate_data = d;
    transfer   = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rec_valid !== (k == LATENCY)) begin
        errors++; $display("FAIL %s_valid_edge%0d got %b want %b", name, k, rec_valid, (k == LATENCY));
      end
      if (k == LATENCY) begin
        checks++;
        if ({rec_module, rec_port, rec_data} !== exp_rec) begin
          errors++; $display("FAIL %s_record got %h want %h", name, {rec_module, rec_port, rec_data}, exp_rec);
        end
      end
      if (k == 10) transfer = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_illegal();
    logic [9:0] addrs [3];
    addrs[0] = 10'b1111111111;   // module 0
    addrs[1] = 10'b0110011110;   // port 3
    addrs[2] = 10'b1111111110;   // qualifier 0
    rec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_strobe(addrs[i], 8'hC3, 10, 8);
      exp_reject++;
    end
    checks++;
    if (rec_count !== 4'd0 || rec_valid !== 1'b0) begin
      errors++; $display("FAIL illegal_no_record got count=%0d valid=%b want 0/0", rec_count, rec_valid);
    end
    checks++;
    if (reject_count !== 8'(exp_reject)) begin
      errors++; $display("FAIL illegal_reject got %0d want %0d", reject_count, exp_reject);
    end
  endtask

  task automatic test_runt();
    drive_strobe(LEGAL_ADDR, 8'h11, 4, 8);
    exp_reject++;
    checks++;
    if (rec_count !== 4'd0) begin errors++; $display("FAIL runt_no_record got %0d want 0", rec_count); end
    checks++;
    if (reject_count !== 8'(exp_reject)) begin
      errors++; $display("FAIL runt_reject got %0d want %0d", reject_count, exp_reject);
    end
  endtask

  task automatic test_overflow();
    pulse_clear();
    checks++;
    if ({overflow, reject_count, drop_count} !== 17'd0) begin
      errors++; $display("FAIL clear_status got ovf=%b rej=%0d drop=%0d want 0", overflow, reject_count, drop_count);
    end
    rec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_strobe(LEGAL_ADDR, 8'(i), 10, 8);
      if (exp_q.size() < DEPTH) exp_q.push_back(make_rec(LEGAL_ADDR, 8'(i)));
      else begin exp_drop++; exp_overflow = 1'b1; end
    end
    checks++;
    if (rec_count !== 4'(exp_q.size())) begin
      errors++; $display("FAIL ovf_count got %0d want %0d", rec_count, exp_q.size());
    end
    checks++;
    if (overflow !== exp_overflow) begin errors++; $display("FAIL ovf_flag got %b want %b", overflow, exp_overflow); end
    checks++;
    if (drop_count !== 8'(exp_drop)) begin
      errors++; $display("FAIL ovf_drop got %0d want %0d", drop_count, exp_drop);
    end
  endtask

  // FIFO is full; rec_ready is raised only during the SAMPLE cycle so the
  // pop and the push land on the same edge.
  task automatic test_full_pop();
    rec_ready = 1'b0;
    @(negedge clk);
    crate_addr = LEGAL_ADDR;
    crate_data = 8'hAA;
    transfer   = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == LATENCY - 1) rec_ready = 1'b1;
      if (k == LATENCY)     rec_ready = 1'b0;
      if (k == 10)          transfer  = 1'b0;
    end
    repeat (8) @(posedge clk);
    #1;
    void'(exp_q.pop_front());
    exp_q.push_back(make_rec(LEGAL_ADDR, 8'hAA));
    checks++;
    if (rec_count !== 4'(exp_q.size())) begin
      errors++; $display("FAIL fullpop_count got %0d want %0d", rec_count, exp_q.size());
    end
    checks++;
    if (drop_count !== 8'(exp_drop)) begin
      errors++; $display("FAIL fullpop_drop got %0d want %0d", drop_count, exp_drop);
    end
  endtask

  task automatic test_drain(input string name);
    logic [14:0] exp_rec;
    rec_ready = 1'b1;
    while (exp_q.size() > 0) begin
      exp_rec = exp_q.pop_front();
      checks++;
      if (rec_valid !== 1'b1 || {rec_module, rec_port, rec_data} !== exp_rec) begin
        errors++; $display("FAIL %s_head got valid=%b rec=%h want valid=1 rec=%h",
                           name, rec_valid, {rec_module, rec_port, rec_data}, exp_rec);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (rec_valid !== 1'b0 || rec_count !== 4'd0) begin
      errors++; $display("FAIL %s_empty got valid=%b count=%0d want 0/0", name, rec_valid, rec_count);
    end
  endtask

  // clear_status lands on the same edge as an illegal-cycle reject.
  task automatic test_clear_priority();
    pulse_clear();
    @(negedge clk);
    crate_addr = 10'h3FF;
    transfer   = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == LATENCY - 1) clear_status = 1'b1;
      if (k == LATENCY)     clear_status = 1'b0;
      if (k == 10)          transfer     = 1'b0;
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (reject_count !== 8'd0) begin
      errors++; $display("FAIL clear_priority_reject got %0d want 0", reject_count);
    end
  endtask

  task automatic test_random();
    logic [9:0] a;
    logic [7:0] d;
    int         high;
    bit         runt;
    pulse_clear();
    rec_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = ~{3'($urandom_range(1, 7)), 2'($urandom_range(0, 2)), 5'($urandom_range(1, 31))};
      end else begin
        a = 10'($urandom_range(0, 1023));
      end
      d    = 8'($urandom_range(0, 255));
      runt = ($urandom_range(0, 3) == 0);
      high = runt ? $urandom_range(1, 4) : $urandom_range(7, 12);
      drive_strobe(a, d, high, 8);
      if (runt || !is_legal(a)) exp_reject++;
      else if (exp_q.size() < DEPTH) exp_q.push_back(make_rec(a, d));
      else begin exp_drop++; exp_overflow = 1'b1; end
    end
    checks++;
    if (reject_count !== 8'(exp_reject)) begin
      errors++; $display("FAIL rand_reject got %0d want %0d", reject_count, exp_reject);
    end
    checks++;
    if (drop_count !== 8'(exp_drop) || overflow !== exp_overflow) begin
      errors++; $display("FAIL rand_drop got %0d/%b want %0d/%b", drop_count, overflow, exp_drop, exp_overflow);
    end
    checks++;
    if (rec_count !== 4'(exp_q.size())) begin
      errors++; $display("FAIL rand_count got %0d want %0d", rec_count, exp_q.size());
    end
    test_drain("rand");
  endtask

  task automatic test_saturate();
    pulse_clear();
    for (int i = 0; i < 260; i++) begin
      drive_strobe(LEGAL_ADDR, 8'h00, 1, 6);
    end
    checks++;
    if (reject_count !== 8'd255) begin
      errors++; $display("FAIL reject_saturate got %0d want 255", reject_count);
    end
  endtask

  task automatic test_mid_reset();
    pulse_clear();
    rec_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_strobe(LEGAL_ADDR, 8'(8'h30 + i), 10, 8);
    checks++;
    if (rec_count !== 4'd3) begin errors++; $display("FAIL midreset_pre_count got %0d want 3", rec_count); end
    @(negedge clk);
    transfer = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    reset    = 1'b1;
    transfer = 1'b0;
    #1;
    checks++;
    if (rec_valid !== 1'b0 || rec_count !== 4'd0) begin
      errors++; $display("FAIL midreset_flush got valid=%b count=%0d want 0/0", rec_valid, rec_count);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    test_legal("post_reset", 8'h77);
  endtask

  initial begin
    test_reset();
    test_legal("legal", 8'h5A);
    test_illegal();
    test_runt();
    test_overflow();
    test_full_pop();
    test_drain("overflow");
    test_clear_priority();
    test_random();
    test_saturate();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
